pot_scanner: RTL and testbench

Round-robin ADC sampler that sits directly upstream of the 16-bit SPI master. It drives the master's `wrt`/`wt_data` handshake to read the slide potentiometers (EQ band gains and volume) through an ADC128S-style 8-channel converter. It continuously scans channels 0..NUM_CH-1 and holds the latest 12-bit result per channel for the equalizer datapath.

---
 rtl/pot_scanner_if.sv | 11 +
 rtl/pot_scanner.sv | 116 +++++++++++
 tb/tb_pot_scanner.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/pot_scanner_if.sv
// Start/done handshake between the pot scanner and the 16-bit SPI master.
// The scanner is the master of this handshake: it issues wrt/wt_data and waits on done.
interface pot_scanner_if;
    logic        wrt;
    logic [15:0] wt_data;
    logic        done;
    logic [15:0] rd_data;

    modport master (output wrt, output wt_data, input done, input rd_data);
    modport slave  (input wrt, input wt_data, output done, output rd_data);
endinterface

// File: rtl/pot_scanner.sv
// Round-robin ADC128S pot sampler: two SPI transactions per channel (command, then readback),
// keeps the latest 12-bit result per channel and pauses between full scans.
module pot_scanner #(
    parameter int NUM_CH       = 7,
    parameter int PAUSE_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    pot_scanner_if.master         spi,
    output logic [12*NUM_CH-1:0]  res,
    output logic [NUM_CH-1:0]     res_vld,
    output logic                  scan_done,
    output logic                  busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WAIT_C,
        S_RD,
        S_WAIT_R,
        S_PAUSE
    } state_t;

    localparam logic [2:0]  LAST_CH    = 3'(NUM_CH - 1);
    localparam logic [15:0] PAUSE_LOAD = 16'(PAUSE_CYCLES - 1);

    state_t      state, state_nxt;
    logic [2:0]  ch, ch_nxt;
    logic [15:0] pause_cnt, pause_nxt;
    logic        store;
    logic        last_ch;
    logic        wrt_q;
    logic [15:0] wt_data_q;

    // The upper nibble of the SPI word carries no conversion data.
    logic unused_rd;
    assign unused_rd = ^spi.rd_data[15:12];

    assign last_ch     = (ch == LAST_CH);
    assign busy        = (state != S_IDLE);
    assign spi.wrt     = wrt_q;
    assign spi.wt_data = wt_data_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt = state;
        ch_nxt    = ch;
        pause_nxt = pause_cnt;
        store     = 1'b0;
        scan_done = 1'b0;
        case (state)
            S_IDLE: begin
                ch_nxt = 3'd0;
                if (en) state_nxt = S_CMD;
            end
            S_CMD:    state_nxt = S_WAIT_C;
            // done is only looked at here and in S_WAIT_R, a clock after wrt, so a stale done is ignored.
            S_WAIT_C: if (spi.done) state_nxt = S_RD;
            S_RD:     state_nxt = S_WAIT_R;
            S_WAIT_R: begin
                if (spi.done) begin
                    store = 1'b1;
                    if (last_ch) begin
                        scan_done = 1'b1;
                        ch_nxt    = 3'd0;
                        pause_nxt = PAUSE_LOAD;
                        state_nxt = S_PAUSE;
                    end else begin
                        ch_nxt    = ch + 3'd1;
                        state_nxt = S_CMD;
                    end
                end
            end
            S_PAUSE: begin
                if (pause_cnt == 16'd0) state_nxt = en ? S_CMD : S_IDLE;
                else                    pause_nxt = pause_cnt - 16'd1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ch        <= 3'd0;
            pause_cnt <= 16'd0;
            wrt_q     <= 1'b0;
            wt_data_q <= 16'h0000;
        end else begin
            state     <= state_nxt;
            ch        <= ch_nxt;
            pause_cnt <= pause_nxt;
            wrt_q     <= (state_nxt == S_CMD) || (state_nxt == S_RD);
            if (state_nxt == S_CMD) wt_data_q <= {2'b00, ch_nxt, 11'h000};
        end
    end

    // NOTE: the result bank is reset, so consumers never see stale values from before a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res     <= '0;
            res_vld <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (store && ch == 3'(k)) begin
                    res[12*k +: 12] <= spi.rd_data[11:0];
                    res_vld[k]      <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pot_scanner.sv
// Self-checking bench: SPI master + ADC128S model with random transaction lengths and random pot
// values, checked against a scan-order reference model.
module tb_pot_scanner;
  localparam int NUM_CH       = 7;
  localparam int PAUSE_CYCLES = 5;
  localparam int SCAN_TXN     = 2 * NUM_CH;
  localparam int BUDGET       = 6000;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 en = 1'b0;
  logic [12*NUM_CH-1:0] res;
  logic [NUM_CH-1:0]    res_vld;
  logic                 scan_done;
  logic                 busy;

  pot_scanner_if bus ();

  pot_scanner #(.NUM_CH(NUM_CH), .PAUSE_CYCLES(PAUSE_CYCLES)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .spi      (bus),
    .res      (res),
    .res_vld  (res_vld),
    .scan_done(scan_done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // SPI master + ADC: each transaction returns the conversion started by the previous command.
  logic [11:0] analog [8];
  logic        m_active;
  int          m_left;
  logic [11:0] m_conv, m_ret;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.done    <= 1'b0;
      bus.rd_data <= 16'h0000;
      m_active    <= 1'b0;
      m_left      <= 0;
      m_conv      <= 12'h000;
      m_ret       <= 12'h000;
    end else if (bus.wrt) begin
      bus.done <= 1'b0;
      m_active <= 1'b1;
      m_left   <= $urandom_range(3, 24);
      m_ret    <= m_conv;
      m_conv   <= analog[bus.wt_data[13:11]];
    end else if (m_active) begin
      if (m_left == 0) begin
        m_active    <= 1'b0;
        bus.done    <= 1'b1;
        bus.rd_data <= {4'($urandom), m_ret};
      end else begin
        m_left      <= m_left - 1;
        bus.rd_data <= 16'($urandom);
      end
    end
  end

  // Reference: transaction n of a session targets channel (n mod 2N)/2; odd ones store the value
  // the pot had at that channel's command transaction.
  logic [11:0]       exp_res [NUM_CH];
  logic [NUM_CH-1:0] exp_vld;
  logic [11:0]       ref_conv;
  logic              waiting_last, exp_sd, prev_wrt, prev_done;
  int cyc = 0, txn = 0, done_cyc = 0, sd_cyc = 0;
  int sd_exp_cnt = 0, sd_obs_cnt = 0, wrt_total = 0;
  int mk, mch;

  function automatic logic [12*NUM_CH-1:0] exp_flat();
    logic [12*NUM_CH-1:0] f;
    for (int k = 0; k < NUM_CH; k++) f[12*k +: 12] = exp_res[k];
    return f;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) exp_res[k] = 12'h000;
      exp_vld      = '0;
      waiting_last = 1'b0;
      prev_wrt     = 1'b0;
      prev_done    = 1'b0;
      txn          = 0;
    end else begin
      cyc++;
      exp_sd = waiting_last && bus.done;
      check("scan_done", scan_done, exp_sd);
      if (scan_done) sd_obs_cnt++;
      if (exp_sd) begin
        waiting_last = 1'b0;
        sd_cyc       = cyc;
        sd_exp_cnt++;
      end
      if (bus.done && !prev_done) done_cyc = cyc;
      if (bus.wrt) begin
        mk  = txn % SCAN_TXN;
        mch = mk / 2;
        check("wrt_width", prev_wrt, 1'b0);
        check("wrt_mid_txn", m_active, 1'b0);
        check("wt_data", bus.wt_data, {2'b00, 3'(mch), 11'h000});
        check("busy_on_wrt", busy, 1'b1);
        check("res", res, exp_flat());
        check("res_vld", res_vld, exp_vld);
        if (txn > 0 && mk == 0) check("pause_gap", cyc - sd_cyc, PAUSE_CYCLES + 1);
        else if (mk != 0)       check("done_to_wrt", cyc - done_cyc, 1);
        if (mk % 2 == 0) begin
          ref_conv = analog[mch];
        end else begin
          exp_res[mch] = ref_conv;
          exp_vld[mch] = 1'b1;
          if (mch == NUM_CH - 1) waiting_last = 1'b1;
        end
        txn++;
        wrt_total++;
      end else if ($urandom_range(0, 3) == 0) begin
        analog[$urandom_range(0, 7)] = 12'($urandom);
      end
      prev_wrt  = bus.wrt;
      prev_done = bus.done;
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_wrt"}, bus.wrt, 1'b0);
    check({tag, "_wt_data"}, bus.wt_data, 16'h0000);
    check({tag, "_res"}, res, '0);
    check({tag, "_res_vld"}, res_vld, '0);
    check({tag, "_scan_done"}, scan_done, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  int t, wrt0, sd_target;

  initial begin
    for (int k = 0; k < 8; k++) analog[k] = 12'($urandom);

    // Reset and idle with en low.
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_reset_values("in_reset");
    #2 rst_n = 1'b1;
    wrt0 = wrt_total;
    repeat (50) @(negedge clk);
    #1;
    check_reset_values("idle_after_reset");
    check("idle_no_wrt", wrt_total - wrt0, 0);

    // Enable: CMD follows the sampling edge, then three full scans back to back.
    en = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    check("start_wrt", bus.wrt, 1'b1);
    t = 0;
    while (sd_exp_cnt < 3 && t < BUDGET) begin @(posedge clk); t++; end
    if (t >= BUDGET) check("timeout_three_scans", 1'b0, 1'b1);
    check("res_vld_full", res_vld, {NUM_CH{1'b1}});

    // Drop en while channel 1 is in flight: the scan completes, pauses, then goes idle.
    t = 0;
    while (!(txn > 3 * SCAN_TXN && txn % SCAN_TXN == 3) && t < BUDGET) begin @(posedge clk); t++; end
    if (t >= BUDGET) check("timeout_ch1", 1'b0, 1'b1);
    #1 en = 1'b0;
    wrt0      = wrt_total;
    sd_target = sd_exp_cnt + 1;
    t = 0;
    while (sd_exp_cnt < sd_target && t < BUDGET) begin @(posedge clk); t++; end
    if (t >= BUDGET) check("timeout_drop_scan", 1'b0, 1'b1);
    for (int i = 0; i < PAUSE_CYCLES; i++) begin
      @(negedge clk); #1;
      check("busy_in_pause", busy, 1'b1);
    end
    @(negedge clk); #1;
    check("busy_after_pause", busy, 1'b0);
    check("drop_txn_count", wrt_total - wrt0, SCAN_TXN - 3);
    repeat (60) @(negedge clk);
    #1;
    check("drop_no_more_wrt", wrt_total - wrt0, SCAN_TXN - 3);
    check("drop_res_retained", res, exp_flat());
    check("drop_vld_retained", res_vld, {NUM_CH{1'b1}});

    // New session, then reset while waiting on the readback of channel 3.
    txn = 0;
    en  = 1'b1;
    t = 0;
    while (txn < 8 && t < BUDGET) begin @(posedge clk); t++; end
    if (t >= BUDGET) check("timeout_ch3_rd", 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    en = 1'b0;
    #1;
    check_reset_values("mid_txn_reset");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    wrt0 = wrt_total;
    repeat (100) @(negedge clk);
    #1;
    check("post_reset_no_wrt", wrt_total - wrt0, 0);
    check_reset_values("post_reset_idle");

    check("scan_done_count", sd_obs_cnt, sd_exp_cnt);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
